// File: rtl/touch_key_gen.sv
// Touch-pad emulator: drives touch_key low for press_len cycles, high for gap_len cycles, repeat_num times.
// One cycle from start to first low; all outputs come from flops; start is ignored while busy.
module touch_key_gen #(
  parameter int CNT_W   = 16,
  parameter int MIN_GAP = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] press_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [3:0]       repeat_num,
  output logic             touch_key,
  output logic             ready,
  output logic             done,
  output logic [3:0]       press_idx
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MIN_GAP_W  = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] MIN_GAP_M1 = CNT_W'(MIN_GAP - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_press_m1, r_gap_m1;
  logic [CNT_W-1:0] w_press_m1, w_gap_m1;
  logic [3:0]       r_num, w_num;
  logic [3:0]       r_idx, w_idx_nxt;
  logic             r_touch_key, r_ready, r_done;
  logic             w_accept;

  // Lengths are stored minus one so the counter terminates on zero.
  always_comb begin
    w_press_m1 = (press_len == '0) ? '0 : press_len - CNT_W'(1);
    w_gap_m1   = (gap_len < MIN_GAP_W) ? MIN_GAP_M1 : gap_len - CNT_W'(1);
    w_num      = (repeat_num == 4'd0) ? 4'd1 : repeat_num;
  end

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = w_press_m1;
          w_idx_nxt   = 4'd1;
        end
      end
      S_PRESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = r_gap_m1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (r_idx < r_num) begin
            w_state_nxt = S_PRESS;
            w_cnt_nxt   = r_press_m1;
            w_idx_nxt   = r_idx + 4'd1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 4'd0;
      r_press_m1  <= '0;
      r_gap_m1    <= '0;
      r_num       <= 4'd0;
      r_touch_key <= 1'b1;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_press_m1 <= w_press_m1;
        r_gap_m1   <= w_gap_m1;
        r_num      <= w_num;
      end
      // Outputs decoded from next state so each one is a clean flop.
      r_touch_key <= (w_state_nxt != S_PRESS);
      r_ready     <= (w_state_nxt == S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign touch_key = r_touch_key;
  assign ready     = r_ready;
  assign done      = r_done;
  assign press_idx = r_idx;

endmodule

// File: tb/tb_touch_key_gen.sv
// Directed bench for touch_key_gen: per-cycle comparison of {touch_key, ready, done, press_idx}.
module tb_touch_key_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic [15:0] press_len = 16'd0;
  logic [15:0] gap_len = 16'd0;
  logic [3:0]  repeat_num = 4'd0;

  logic        touch_key, ready, done;
  logic [3:0]  press_idx;
  logic        touch_key4, ready4, done4;
  logic [3:0]  press_idx4;

  wire [6:0] obs  = {touch_key, ready, done, press_idx};
  wire [6:0] obs4 = {touch_key4, ready4, done4, press_idx4};

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  touch_key_gen #(.CNT_W(16), .MIN_GAP(4)) u_dut (
    .sys_clk(clk), .sys_rst(rst), .start(start),
    .press_len(press_len), .gap_len(gap_len), .repeat_num(repeat_num),
    .touch_key(touch_key), .ready(ready), .done(done), .press_idx(press_idx)
  );

  touch_key_gen #(.CNT_W(4), .MIN_GAP(4)) u_dut4 (
    .sys_clk(clk), .sys_rst(rst), .start(start4),
    .press_len(press_len[3:0]), .gap_len(gap_len[3:0]), .repeat_num(repeat_num),
    .touch_key(touch_key4), .ready(ready4), .done(done4), .press_idx(press_idx4)
  );

  // Expected {touch_key, ready, done, press_idx} t cycles after the accepting edge.
  function automatic logic [6:0] exp_vec(input int t, input int p, input int g, input int n);
    int per;
    per = p + g;
    if (t < n * per)
      return {((t % per) >= p), 1'b0, 1'b0, 4'(t / per + 1)};
    else if (t == n * per)
      return {1'b1, 1'b0, 1'b1, 4'(n)};
    else
      return {1'b1, 1'b1, 1'b0, 4'(n)};
  endfunction

  // Presents inputs with start for one cycle; returns just after the accepting edge.
  task automatic launch(input int p, input int g, input int n, input bit use4, input bit hold);
    @(posedge clk); #1;
    press_len  = 16'(p);
    gap_len    = 16'(g);
    repeat_num = 4'(n);
    if (use4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start  = 1'b0;
      start4 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b1100000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, 7'b1100000);
      end
      checks++;
      if (obs4 !== 7'b1100000) begin
        errors++;
        $display("FAIL reset_idle4 cyc=%0d got=%b exp=%b", i, obs4, 7'b1100000);
      end
    end
  endtask

  task automatic test_basic();
    int ndone;
    ndone = 0;
    launch(15, 10, 2, 1'b0, 1'b0);
    for (int t = 0; t < 53; t++) begin
      @(negedge clk);
      if (done) ndone++;
      checks++;
      if (obs !== exp_vec(t, 15, 10, 2)) begin
        errors++;
        $display("FAIL basic t=%0d got=%b exp=%b", t, obs, exp_vec(t, 15, 10, 2));
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL basic_done_count got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_clamp();
    launch(0, 1, 0, 1'b0, 1'b0);
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(t, 1, 4, 1)) begin
        errors++;
        $display("FAIL clamp t=%0d got=%b exp=%b", t, obs, exp_vec(t, 1, 4, 1));
      end
    end
  endtask

  task automatic test_busy_ignored();
    int ndone;
    ndone = 0;
    launch(8, 8, 1, 1'b0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      if (done) ndone++;
      checks++;
      if (obs !== exp_vec(t, 8, 8, 1)) begin
        errors++;
        $display("FAIL busy t=%0d got=%b exp=%b", t, obs, exp_vec(t, 8, 8, 1));
      end
      if (t == 3) begin
        press_len  = 16'd2;
        gap_len    = 16'd5;
        repeat_num = 4'd3;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_done_count got=%0d exp=1", ndone);
    end
  endtask

  task automatic test_reset_mid_press();
    int ndone;
    ndone = 0;
    launch(100, 10, 1, 1'b0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(t, 100, 10, 1)) begin
        errors++;
        $display("FAIL rst_mid_pre t=%0d got=%b exp=%b", t, obs, exp_vec(t, 100, 10, 1));
      end
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (obs !== 7'b1100000) begin
      errors++;
      $display("FAIL rst_mid_edge got=%b exp=%b", obs, 7'b1100000);
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) ndone++;
      checks++;
      if (obs !== 7'b1100000) begin
        errors++;
        $display("FAIL rst_mid_after t=%0d got=%b exp=%b", t, obs, 7'b1100000);
      end
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rst_mid_done got=%0d exp=0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    // P=2, G=4, N=1: 6 active + done + one ready cycle = 8-cycle period.
    launch(2, 4, 1, 1'b0, 1'b1);
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(t % 8, 2, 4, 1)) begin
        errors++;
        $display("FAIL b2b t=%0d got=%b exp=%b", t, obs, exp_vec(t % 8, 2, 4, 1));
      end
      if (t == 23) start = 1'b0;
    end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b1100001) begin
        errors++;
        $display("FAIL b2b_stop t=%0d got=%b exp=%b", t, obs, 7'b1100001);
      end
    end
  endtask

  task automatic test_max_len();
    launch(15, 15, 3, 1'b1, 1'b0);
    for (int t = 0; t < 93; t++) begin
      @(negedge clk);
      checks++;
      if (obs4 !== exp_vec(t, 15, 15, 3)) begin
        errors++;
        $display("FAIL maxlen t=%0d got=%b exp=%b", t, obs4, exp_vec(t, 15, 15, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_busy_ignored();
    test_reset_mid_press();
    test_back_to_back();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
